// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core: access size codes, memory-stage
// FSM state encoding and the alignment rule used by the memory stage.
package mips_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_REQ  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // The reserved size code behaves as a word access everywhere.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
        logic ok;
        case (size)
            SZ_HALF: ok = ~off[0];
            SZ_BYTE: ok = 1'b1;
            default: ok = (off == 2'b00);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the memory stage: store byte enables and data
// replication, plus load extraction with sign/zero extension.
module mem_lane_align
    import mips_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_off,
    input  logic        ld_signed,
    input  logic [31:0] ld_word,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ld_data
);

    logic [31:0] shifted;

    always_comb begin
        be    = 4'b1111;
        wdata = st_data;
        case (st_size)
            SZ_HALF: begin
                be    = st_off[1] ? 4'b1100 : 4'b0011;
                wdata = {st_data[15:0], st_data[15:0]};
            end
            SZ_BYTE: begin
                be    = 4'b0001 << st_off;
                wdata = {4{st_data[7:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = st_data;
            end
        endcase
    end

    // Little-endian: the addressed lane is moved down to bit 0 first.
    assign shifted = ld_word >> {ld_off, 3'b000};

    always_comb begin
        ld_data = ld_word;
        case (ld_size)
            SZ_HALF: ld_data = {{16{ld_signed & shifted[15]}}, shifted[15:0]};
            SZ_BYTE: ld_data = {{24{ld_signed & shifted[7]}}, shifted[7:0]};
            default: ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM stage of the pipelined MIPS core: runs loads/stores over a req/ready
// handshake, stalls upstream while busy and drives MEM/WB control and data.
module mem_access
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wreg,
    input  logic        m2reg,
    input  logic        wmem,
    input  logic [1:0]  size,
    input  logic        lsigned,
    input  logic [4:0]  rd_rt,
    input  logic [31:0] r,
    input  logic [31:0] di,
    output logic        stall,
    output logic        misalign,
    output logic        wreg_out,
    output logic        m2reg_out,
    output logic [4:0]  rd_rt_out,
    output logic [31:0] r_out,
    output logic [31:0] do_out,
    output logic        dm_req,
    output logic        dm_we,
    output logic [29:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ready
);

    // Handshake: dm_req is held high from the first REQ cycle until the
    // cycle in which dm_ready is seen high; address, direction, enables and
    // write data are registered and so stay stable for that whole window.

    state_t      state;
    logic        mem_op;
    logic        aligned;
    logic        access;
    logic        we_q;
    logic [29:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [31:0] data_q;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] lane_ld;

    assign mem_op  = m2reg | wmem;
    assign aligned = is_aligned(size, r[1:0]);
    assign access  = mem_op & aligned;

    mem_lane_align u_align (
        .st_size   (size),
        .st_off    (r[1:0]),
        .st_data   (di),
        .ld_size   (size_q),
        .ld_off    (off_q),
        .ld_signed (signed_q),
        .ld_word   (dm_rdata),
        .be        (lane_be),
        .wdata     (lane_wdata),
        .ld_data   (lane_ld)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            off_q    <= '0;
            size_q   <= SZ_WORD;
            signed_q <= 1'b0;
            data_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (access) begin
                        state    <= ST_REQ;
                        we_q     <= wmem;
                        addr_q   <= r[31:2];
                        be_q     <= lane_be;
                        wdata_q  <= wmem ? lane_wdata : 32'h0;
                        off_q    <= r[1:0];
                        size_q   <= size;
                        signed_q <= lsigned;
                    end
                end
                ST_REQ: begin
                    if (dm_ready) begin
                        data_q <= we_q ? 32'h0 : lane_ld;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Write-back is a bubble while stalled and for misaligned accesses;
    // a combined load+store retires as a store with no register write.
    always_comb begin
        stall    = 1'b0;
        wreg_out = 1'b0;
        do_out   = 32'h0;
        case (state)
            ST_IDLE: begin
                stall    = access;
                wreg_out = wreg & ~mem_op;
            end
            ST_REQ: stall = 1'b1;
            ST_DONE: begin
                wreg_out = wreg & ~wmem;
                do_out   = data_q;
            end
            default: stall = 1'b0;
        endcase
    end

    assign misalign  = mem_op & ~aligned;
    assign m2reg_out = m2reg & ~wmem;
    assign rd_rt_out = rd_rt;
    assign r_out     = r;

    assign dm_req   = (state == ST_REQ);
    assign dm_we    = we_q;
    assign dm_addr  = addr_q;
    assign dm_be    = be_q;
    assign dm_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: a vector table of loads/stores/bubbles
// with hand-computed results, plus a reset-during-request sequence.
module tb_mem_access;

    logic        clk;
    logic        rst_n;
    logic        wreg;
    logic        m2reg;
    logic        wmem;
    logic [1:0]  size;
    logic        lsigned;
    logic [4:0]  rd_rt;
    logic [31:0] r;
    logic [31:0] di;
    logic        stall;
    logic        misalign;
    logic        wreg_out;
    logic        m2reg_out;
    logic [4:0]  rd_rt_out;
    logic [31:0] r_out;
    logic [31:0] do_out;
    logic        dm_req;
    logic        dm_we;
    logic [29:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ready;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        wreg;
        logic        m2reg;
        logic        wmem;
        logic [1:0]  size;
        logic        lsigned;
        logic [4:0]  rd;
        logic [31:0] r;
        logic [31:0] di;
        logic [31:0] rdata;
        int          delay;
        logic        e_access;
        logic        e_mis;
        logic        e_we;
        logic        e_wreg;
        logic        e_m2r;
        logic [3:0]  e_be;
        logic [29:0] e_addr;
        logic [31:0] e_wdata;
        logic [31:0] e_do;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs[NV];

    mem_access dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wreg      (wreg),
        .m2reg     (m2reg),
        .wmem      (wmem),
        .size      (size),
        .lsigned   (lsigned),
        .rd_rt     (rd_rt),
        .r         (r),
        .di        (di),
        .stall     (stall),
        .misalign  (misalign),
        .wreg_out  (wreg_out),
        .m2reg_out (m2reg_out),
        .rd_rt_out (rd_rt_out),
        .r_out     (r_out),
        .do_out    (do_out),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_be     (dm_be),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_ready  (dm_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        wreg    = v.wreg;
        m2reg   = v.m2reg;
        wmem    = v.wmem;
        size    = v.size;
        lsigned = v.lsigned;
        rd_rt   = v.rd;
        r       = v.r;
        di      = v.di;
    endtask

    task automatic clear_inputs();
        wreg = 0; m2reg = 0; wmem = 0; size = 0; lsigned = 0;
        rd_rt = 0; r = 0; di = 0; dm_rdata = 0; dm_ready = 0;
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        int   st_cnt;
        v = vecs[i];
        st_cnt = 0;
        @(posedge clk); #1;
        drive(v);
        dm_ready = 1'b0;
        #1;
        check($sformatf("v%0d misalign", i), {31'b0, misalign}, {31'b0, v.e_mis});
        check($sformatf("v%0d idle_stall", i), {31'b0, stall}, {31'b0, v.e_access});
        check($sformatf("v%0d idle_req", i), {31'b0, dm_req}, 32'h0);
        check($sformatf("v%0d m2reg_out", i), {31'b0, m2reg_out}, {31'b0, v.e_m2r});
        if (stall) st_cnt++;
        if (!v.e_access) begin
            check($sformatf("v%0d wreg_out", i), {31'b0, wreg_out}, {31'b0, v.e_wreg});
            check($sformatf("v%0d do_out", i), do_out, 32'h0);
            check($sformatf("v%0d rd_rt_out", i), {27'b0, rd_rt_out}, {27'b0, v.rd});
            check($sformatf("v%0d r_out", i), r_out, v.r);
            // The bubble must not start a request on the following edge.
            @(posedge clk); #2;
            check($sformatf("v%0d no_req", i), {31'b0, dm_req}, 32'h0);
        end else begin
            check($sformatf("v%0d idle_wreg", i), {31'b0, wreg_out}, 32'h0);
            for (int c = 0; c <= v.delay; c++) begin
                @(posedge clk); #1;
                if (c == v.delay) begin
                    dm_ready = 1'b1;
                    dm_rdata = v.rdata;
                end else begin
                    dm_ready = 1'b0;
                    dm_rdata = ~v.rdata;
                end
                #1;
                check($sformatf("v%0d req", i), {31'b0, dm_req}, 32'h1);
                check($sformatf("v%0d addr", i), {2'b0, dm_addr}, {2'b0, v.e_addr});
                check($sformatf("v%0d be", i), {28'b0, dm_be}, {28'b0, v.e_be});
                check($sformatf("v%0d we", i), {31'b0, dm_we}, {31'b0, v.e_we});
                if (v.e_we) check($sformatf("v%0d wdata", i), dm_wdata, v.e_wdata);
                check($sformatf("v%0d req_wreg", i), {31'b0, wreg_out}, 32'h0);
                if (stall) st_cnt++;
            end
            @(posedge clk); #1;
            dm_ready = 1'b0;
            dm_rdata = 32'h0;
            #1;
            check($sformatf("v%0d done_req", i), {31'b0, dm_req}, 32'h0);
            check($sformatf("v%0d do_out", i), do_out, v.e_do);
            check($sformatf("v%0d done_wreg", i), {31'b0, wreg_out}, {31'b0, v.e_wreg});
            if (stall) st_cnt++;
            check($sformatf("v%0d stall_cycles", i), st_cnt, 32'(v.delay + 2));
        end
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 5'd3,  32'h100, 32'h0,        32'hDEADBEEF, 0,
                     1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'hF, 30'h40, 32'h0,        32'hDEADBEEF};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 2'b10, 1'b1, 5'd4,  32'h103, 32'h0,        32'h80FFFF7F, 0,
                     1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'h8, 30'h40, 32'h0,        32'hFFFFFF80};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 5'd4,  32'h103, 32'h0,        32'h80FFFF7F, 1,
                     1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'h8, 30'h40, 32'h0,        32'h00000080};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 5'd0,  32'h102, 32'h1234ABCD, 32'h0,        0,
                     1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'hC, 30'h40, 32'hABCDABCD, 32'h0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 5'd7,  32'h200, 32'h0,        32'h01234567, 3,
                     1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'hF, 30'h80, 32'h0,        32'h01234567};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 5'd8,  32'h101, 32'h0,        32'h0,        0,
                     1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 30'h0,  32'h0,        32'h0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 5'd9,  32'h55,  32'h0,        32'h0,        0,
                     1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 30'h0,  32'h0,        32'h0};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 5'd10, 32'h106, 32'h0,        32'h80011234, 0,
                     1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'hC, 30'h41, 32'h0,        32'hFFFF8001};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 5'd0,  32'h101, 32'h000000A5, 32'h0,        2,
                     1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h2, 30'h40, 32'hA5A5A5A5, 32'h0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 5'd0,  32'h102, 32'h5,        32'h0,        0,
                     1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 30'h0,  32'h0,        32'h0};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 5'd11, 32'h10,  32'h11223344, 32'h0,        0,
                     1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'hF, 30'h4,  32'h11223344, 32'h0};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 5'd12, 32'h20,  32'h0,        32'hCAFEF00D, 0,
                     1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'hF, 30'h8,  32'h0,        32'hCAFEF00D};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 5'd13, 32'h102, 32'h0,        32'h12345678, 0,
                     1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'h4, 30'h40, 32'h0,        32'h00000034};

        clear_inputs();
        rst_n = 1'b0;
        #12;
        check("rst dm_req", {31'b0, dm_req}, 32'h0);
        check("rst dm_we", {31'b0, dm_we}, 32'h0);
        check("rst dm_be", {28'b0, dm_be}, 32'h0);
        check("rst dm_addr", {2'b0, dm_addr}, 32'h0);
        check("rst dm_wdata", dm_wdata, 32'h0);
        check("rst do_out", do_out, 32'h0);
        check("rst stall", {31'b0, stall}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) run_vec(i);

        // Reset while a request is outstanding, then a normal access.
        @(posedge clk); #1;
        drive(vecs[0]);
        @(posedge clk); #2;
        check("rstreq req_before", {31'b0, dm_req}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("rstreq req_drop", {31'b0, dm_req}, 32'h0);
        check("rstreq addr", {2'b0, dm_addr}, 32'h0);
        check("rstreq be", {28'b0, dm_be}, 32'h0);
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(4);
        run_vec(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
